// File: rtl/rns_reverse_conv_789.sv
// Residue-to-binary converter for the {7, 8, 9} moduli set using mixed-radix conversion.
// Optional macro RNS_RC_RANGE_CHECK_EN flags illegal residues via err and forces x = 0.
module rns_reverse_conv_789 (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] r7,
    input  logic [2:0] r8,
    input  logic [3:0] r9,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] x,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S_A2  = 3'd1,
        S_A3  = 3'd2,
        S_SUM = 3'd3,
        S_OUT = 3'd4
    } state_t;

    // Fold an out-of-range residue back into range with a single modulus subtraction.
    function automatic logic [2:0] red7(input logic [2:0] v);
        red7 = (v == 3'd7) ? 3'd0 : v;
    endfunction

    function automatic logic [3:0] red9(input logic [3:0] v);
        red9 = (v > 4'd8) ? (v - 4'd9) : v;
    endfunction

    function automatic logic [2:0] sub_mod7(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        logic [3:0] r;
        s = {1'b0, a} + 4'd7 - {1'b0, b};
        r = (s >= 4'd7) ? (s - 4'd7) : s;
        sub_mod7 = r[2:0];
    endfunction

    function automatic logic [3:0] sub_mod9(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        logic [4:0] r;
        s = {1'b0, a} + 5'd9 - {1'b0, b};
        r = (s >= 5'd9) ? (s - 5'd9) : s;
        sub_mod9 = r[3:0];
    endfunction

    // 8 is congruent to -1 mod 9, so multiplying by 8 is a modular negation.
    function automatic logic [3:0] neg_mod9(input logic [3:0] d);
        neg_mod9 = (d == 4'd0) ? 4'd0 : (4'd9 - d);
    endfunction

    function automatic logic [3:0] mul4_mod9(input logic [3:0] e);
        logic [5:0] p;
        logic [5:0] r;
        p = {e, 2'b00};
        if (p >= 6'd27) begin
            r = p - 6'd27;
        end else if (p >= 6'd18) begin
            r = p - 6'd18;
        end else if (p >= 6'd9) begin
            r = p - 6'd9;
        end else begin
            r = p;
        end
        mul4_mod9 = r[3:0];
    endfunction

    state_t     state_q, state_d;
    logic [2:0] r7_q, r7_d;
    logic [2:0] r8_q, r8_d;
    logic [3:0] r9_q, r9_d;
    logic [2:0] a1_q, a1_d;
    logic [2:0] a2_q, a2_d;
    logic [3:0] t_q, t_d;
    logic [3:0] a3_q, a3_d;
    logic [8:0] x_q, x_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic [8:0] sum_s;
`ifdef RNS_RC_RANGE_CHECK_EN
    logic       bad_q, bad_d;
    logic       err_q, err_d;
`endif

    assign sum_s = {6'b000000, a1_q} + {3'b000, a2_q, 3'b000}
                 + {a3_q, 5'b00000} + {1'b0, a3_q, 4'b0000} + {2'b00, a3_q, 3'b000};

    // Next-state and datapath register updates for each conversion step.
    always_comb begin
        state_d = state_q;
        r7_d    = r7_q;
        r8_d    = r8_q;
        r9_d    = r9_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        t_d     = t_q;
        a3_d    = a3_q;
        x_d     = x_q;
`ifdef RNS_RC_RANGE_CHECK_EN
        bad_d   = bad_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    r7_d    = r7;
                    r8_d    = r8;
                    r9_d    = r9;
                    state_d = S_A2;
                end else begin
                    state_d = IDLE;
                end
            end
            S_A2: begin
                a1_d    = r8_q;
                a2_d    = sub_mod7(red7(r7_q), red7(r8_q));
                t_d     = neg_mod9(sub_mod9(red9(r9_q), {1'b0, r8_q}));
`ifdef RNS_RC_RANGE_CHECK_EN
                bad_d   = (r7_q == 3'd7) || (r9_q > 4'd8);
`endif
                state_d = S_A3;
            end
            S_A3: begin
                a3_d    = mul4_mod9(sub_mod9(t_q, {1'b0, a2_q}));
                state_d = S_SUM;
            end
            S_SUM: begin
`ifdef RNS_RC_RANGE_CHECK_EN
                x_d   = bad_q ? 9'd0 : sum_s;
                err_d = bad_q;
`else
                x_d   = sum_s;
`endif
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == S_OUT);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            r7_q        <= 3'd0;
            r8_q        <= 3'd0;
            r9_q        <= 4'd0;
            a1_q        <= 3'd0;
            a2_q        <= 3'd0;
            t_q         <= 4'd0;
            a3_q        <= 4'd0;
            x_q         <= 9'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef RNS_RC_RANGE_CHECK_EN
            bad_q       <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            r7_q        <= r7_d;
            r8_q        <= r8_d;
            r9_q        <= r9_d;
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            t_q         <= t_d;
            a3_q        <= a3_d;
            x_q         <= x_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef RNS_RC_RANGE_CHECK_EN
            bad_q       <= bad_d;
            err_q       <= err_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign x         = x_q;
`ifdef RNS_RC_RANGE_CHECK_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_rns_reverse_conv_789.sv
// Scoreboard bench for rns_reverse_conv_789: CRT search reference, latency,
// backpressure, mid-flight reset and illegal-residue handling.
module tb_rns_reverse_conv_789;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] r7 = 3'd0;
    logic [2:0] r8 = 3'd0;
    logic [3:0] r9 = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [8:0] x;
    logic       err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit bp_rand = 1'b0;
    bit pending = 1'b0;

    typedef struct {
        int x;
        int err;
        int acc;
    } exp_t;
    exp_t q[$];

    rns_reverse_conv_789 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .r7(r7), .r8(r8), .r9(r9), .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: find the unique X in [0,503] with the given residues.
    function automatic exp_t model(input int a, input int b, input int c);
        exp_t e;
        e.x = 0;
        e.err = 0;
        e.acc = 0;
        if (a == 7 || c > 8) begin
`ifdef RNS_RC_RANGE_CHECK_EN
            e.err = 1;
            return e;
`else
            if (a == 7) a = 0;
            if (c > 8) c = c - 9;
`endif
        end
        for (int v = 0; v < 504; v++) begin
            if (v % 7 == a && v % 8 == b && v % 9 == c) e.x = v;
        end
        return e;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (bp_rand) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic send(input int a, input int b, input int c);
        exp_t e;
        int n;
        r7 = 3'(a);
        r8 = 3'(b);
        r9 = 4'(c);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            e = model(a, b, c);
            e.acc = cyc + 1;
            q.push_back(e);
            tick();
            in_valid = 1'b0;
        end
    endtask

    // Monitor: pop on the first cycle of each result, then check it holds until taken.
    int held_x;
    int held_err;
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (rst) begin
            pending = 1'b0;
        end else if (out_valid) begin
            check("in_ready_low_while_out", int'(in_ready), 0);
            if (!pending) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("x", int'(x), e.x);
                    check("err", int'(err), e.err);
                    check("latency_edges", cyc - e.acc, 3);
                end
                held_x = int'(x);
                held_err = int'(err);
                pending = 1'b1;
            end else begin
                check("x_hold", int'(x), held_x);
                check("err_hold", int'(err), held_err);
            end
            if (out_ready) pending = 1'b0;
        end
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_x", int'(x), 0);
        check("rst_err", int'(err), 0);

        send(2, 4, 1);
        check("busy_in_ready", int'(in_ready), 0);
        send(0, 0, 0);
        send(6, 7, 8);
        send(7, 3, 12);

        // Backpressure with ignored input pulses.
        n = 0;
        while ((q.size() != 0 || pending) && n < 100) begin tick(); n++; end
        out_ready = 1'b0;
        send(3, 5, 7);
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        check("bp_out_valid", int'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'(i % 2);
            r7 = 3'($urandom_range(0, 6));
            r8 = 3'($urandom_range(0, 7));
            r9 = 4'($urandom_range(0, 8));
            tick();
            check("bp_valid_hold", int'(out_valid), 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", int'(in_ready), 1);
        check("bp_release_out_valid", int'(out_valid), 0);

        // Reset while in S_A3 discards the conversion.
        send(1, 2, 3);
        tick();
        rst = 1'b1;
        q.delete();
        tick();
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_x", int'(x), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        rst = 1'b0;
        repeat (10) tick();

        // Exhaustive sweep of legal triples.
        for (int a = 0; a < 7; a++)
            for (int b = 0; b < 8; b++)
                for (int c = 0; c < 9; c++)
                    send(a, b, c);

        // Random triples including illegal codes, random backpressure.
        bp_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 15));
        end
        bp_rand = 1'b0;
        out_ready = 1'b1;

        n = 0;
        while ((q.size() != 0 || pending) && n < 300) begin tick(); n++; end
        check("drain_queue", q.size(), 0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
